sender_arbiter: RTL and testbench
=================================

SENDER_ARBITER -- requirements
Module: sender_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL set the maximum cycles spent waiting for each Ack edge before abort (8-bit, 1..255).
REQ-002 clk  input  1  SHALL be the rising-edge clock for all state.
REQ-003 Reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 cli_req  input  4  SHALL carry per-client transfer requests, level, held until cli_done or cli_err.
REQ-005 cli_data  input  64  SHALL carry client words; client i occupies bits [16i+15:16i].
REQ-006 cli_grant  output  4  SHALL be one-hot, marking the client owning the link.
REQ-007 cli_done  output  4  SHALL give a one-cycle pulse to the owner on successful handshake completion.
REQ-008 cli_err  output  4  SHALL give a one-cycle pulse to the owner on timeout abort.
REQ-009 Ack  input  1  SHALL be the receiver acknowledge, asynchronous to clk.
REQ-010 Request  output  1  SHALL be the 4-phase link request, registered.
REQ-011 sdrDataOut  output  16  SHALL be the link data, registered and stable while Request=1.
REQ-012 busy  output  1  SHALL be high in every state except IDLE.

Function
REQ-013 Ack SHALL pass through a 2-flop synchronizer (ack_s); all FSM decisions SHALL use ack_s only.
REQ-014 FSM states SHALL be IDLE, REQ_HIGH, REQ_LOW, DONE, ABORT.
REQ-015 IDLE: with any cli_req bit set, the block SHALL pick a winner round-robin, searching from (ptr+1) mod 4 upward with wrap; ptr is the last-served index.
REQ-016 On the IDLE->REQ_HIGH edge, the block SHALL register sdrDataOut <= winner's word, cli_grant <= onehot(winner), Request <= 1 and timer <= 0, all in the same edge.
REQ-017 REQ_HIGH: Request SHALL stay 1; on ack_s=1 the FSM SHALL go to REQ_LOW and Request SHALL drop to 0 on that edge.
REQ-018 REQ_LOW: Request SHALL stay 0; on ack_s=0 the FSM SHALL go to DONE.
REQ-019 DONE: cli_done[winner]=1 for exactly one cycle, cli_grant SHALL clear, ptr <= winner, and the FSM SHALL return to IDLE.
REQ-020 Timer SHALL count cycles in REQ_HIGH and in REQ_LOW, cleared on each entry to either state; on timer==TIMEOUT without the awaited ack_s level, the FSM SHALL enter ABORT.
REQ-021 ABORT: Request=0, cli_err[winner]=1 for one cycle, cli_grant SHALL clear, ptr <= winner, and the FSM SHALL go to IDLE only when ack_s=0; otherwise it SHALL hold ABORT with cli_err low after the first cycle.
REQ-022 A new arbitration SHALL NOT start in the DONE or ABORT cycle; the minimum gap between transfers is 1 IDLE cycle.
REQ-023 Deassertion of the owner's cli_req mid-transfer SHALL be ignored; the handshake SHALL complete or time out normally.
REQ-024 Changes on cli_data after grant SHALL NOT affect sdrDataOut until the next grant.
REQ-025 With several requests in the same cycle, exactly one grant SHALL issue; no client SHALL wait more than 3 transfers while its request is held.
REQ-026 Ack=1 while in IDLE SHALL NOT start a transfer; the next transfer SHALL wait in REQ_HIGH as normal (the stale Ack completes it).

Reset
REQ-027 Reset SHALL force immediately: state=IDLE, Request=0, sdrDataOut=0, cli_grant=0, cli_done=0, cli_err=0, busy=0, ptr=3 (client 0 first), timer=0, sync flops=0.
REQ-028 Reset mid-transfer SHALL abandon the transfer without a done or err pulse.

Verification
REQ-029 Single client: cli_req=0001, word0=16'hA5A5, Ack echoes Request with 1-cycle delay -> Request high 1 cycle after req, sdrDataOut=A5A5, one cli_done[0] pulse, busy low afterwards.
REQ-030 Contention: cli_req=1111 held, distinct words 1111/2222/3333/4444 -> grant order 0,1,2,3,0, and each word is seen on sdrDataOut in that order.
REQ-031 Wrap: after serving client 3, cli_req=1001 -> client 0 is granted before client 3.
REQ-032 Timeout: TIMEOUT=10, Ack tied low -> Request falls 10 cycles after REQ_HIGH entry, one cli_err pulse, no cli_done, next client then granted.
REQ-033 Stuck Ack: Ack rises and never falls -> ABORT after TIMEOUT in REQ_LOW, FSM holds ABORT until Ack is released, then IDLE.
REQ-034 Reset asserted during REQ_HIGH -> Request=0 and cli_grant=0 asynchronously, no pulses, and the first grant after release goes to client 0.

Source files
------------

// File: rtl/sender_arbiter.sv
// Round-robin arbiter for 4 clients sharing one 4-phase Request/Ack link.
// Latency: grant, Request and link word register on the edge after a request is seen in IDLE.
// Backpressure: clients hold cli_req until cli_done/cli_err; each Ack edge is awaited up to TIMEOUT cycles.
module sender_arbiter #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        Reset,
   input  logic [3:0]  cli_req,
   input  logic [63:0] cli_data,
   output logic [3:0]  cli_grant,
   output logic [3:0]  cli_done,
   output logic [3:0]  cli_err,
   input  logic        Ack,
   output logic        Request,
   output logic [15:0] sdrDataOut,
   output logic        busy
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      REQ_HIGH = 3'd1,
      REQ_LOW  = 3'd2,
      DONE     = 3'd3,
      ABORT    = 3'd4
   } state_t;

   // Abort fires on the edge that ends the TIMEOUT-th cycle spent waiting in a state.
   localparam logic [7:0] TLIM = 8'(TIMEOUT - 1);

   state_t      state;
   logic        ack_m;
   logic        ack_s;
   logic [1:0]  ptr;
   logic [1:0]  winner;
   logic [1:0]  pick;
   logic        pick_vld;
   logic [15:0] pick_dat;
   logic [7:0]  timer;

   // Two-flop synchronizer; the FSM only ever looks at ack_s.
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         ack_m <= 1'b0;
         ack_s <= 1'b0;
      end else begin
         ack_m <= Ack;
         ack_s <= ack_m;
      end
   end

   // Round-robin pick: scan from ptr+4 (ptr itself, lowest priority) down to ptr+1 so the
   // closest requester after the last-served client wins.
   always_comb begin
      pick     = ptr;
      pick_vld = 1'b0;
      for (int i = 4; i >= 1; i--) begin
         if (cli_req[ptr + 2'(i)]) begin
            pick     = ptr + 2'(i);
            pick_vld = 1'b1;
         end
      end
      pick_dat = cli_data[{pick, 4'b0000} +: 16];
   end

   // Handshake FSM with all outputs registered; done/err default low so they pulse for one cycle.
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         state      <= IDLE;
         Request    <= 1'b0;
         sdrDataOut <= 16'h0000;
         cli_grant  <= 4'b0000;
         cli_done   <= 4'b0000;
         cli_err    <= 4'b0000;
         busy       <= 1'b0;
         ptr        <= 2'd3;
         winner     <= 2'd0;
         timer      <= 8'd0;
      end else begin
         cli_done <= 4'b0000;
         cli_err  <= 4'b0000;
         case (state)
            IDLE: begin
               if (pick_vld) begin
                  state      <= REQ_HIGH;
                  winner     <= pick;
                  sdrDataOut <= pick_dat;
                  cli_grant  <= 4'b0001 << pick;
                  Request    <= 1'b1;
                  timer      <= 8'd0;
                  busy       <= 1'b1;
               end
            end
            REQ_HIGH: begin
               if (ack_s) begin
                  state   <= REQ_LOW;
                  Request <= 1'b0;
                  timer   <= 8'd0;
               end else if (timer == TLIM) begin
                  state     <= ABORT;
                  Request   <= 1'b0;
                  cli_err   <= 4'b0001 << winner;
                  cli_grant <= 4'b0000;
                  ptr       <= winner;
               end else begin
                  timer <= timer + 8'd1;
               end
            end
            REQ_LOW: begin
               if (!ack_s) begin
                  state     <= DONE;
                  cli_done  <= 4'b0001 << winner;
                  cli_grant <= 4'b0000;
                  ptr       <= winner;
               end else if (timer == TLIM) begin
                  state     <= ABORT;
                  cli_err   <= 4'b0001 << winner;
                  cli_grant <= 4'b0000;
                  ptr       <= winner;
               end else begin
                  timer <= timer + 8'd1;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            ABORT: begin
               // Wait for the receiver to release Ack so the next transfer starts clean.
               if (!ack_s) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               Request <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sender_arbiter.sv
// Directed bench for sender_arbiter (TIMEOUT=10), one task per scenario.
// Latency: expected cycle offsets are hand-derived from the 2-flop Ack synchronizer.
// Backpressure: Ack is either echoed from Request at the falling edge or driven directly.
module tb_sender_arbiter;

   logic        clk = 1'b0;
   logic        Reset = 1'b1;
   logic [3:0]  cli_req = 4'b0000;
   logic [63:0] cli_data = 64'h0;
   logic [3:0]  cli_grant;
   logic [3:0]  cli_done;
   logic [3:0]  cli_err;
   logic        Ack = 1'b0;
   logic        Request;
   logic [15:0] sdrDataOut;
   logic        busy;

   logic        echo_en = 1'b0;
   int          tests_run = 0;
   int          fails = 0;

   sender_arbiter #(.TIMEOUT(10)) dut (
      .clk        (clk),
      .Reset      (Reset),
      .cli_req    (cli_req),
      .cli_data   (cli_data),
      .cli_grant  (cli_grant),
      .cli_done   (cli_done),
      .cli_err    (cli_err),
      .Ack        (Ack),
      .Request    (Request),
      .sdrDataOut (sdrDataOut),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Receiver model: Ack follows Request half a cycle later when echoing.
   always @(negedge clk) if (echo_en) Ack = Request;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      Reset = 1'b1; echo_en = 1'b0; Ack = 1'b0; cli_req = 4'b0000;
      tick(); tick();
      Reset = 1'b0;
   endtask

   task automatic test_reset();
      tick();
      tests_run++;
      if ({Request, busy, cli_grant, cli_done, cli_err, sdrDataOut} !== 30'd0) begin
         fails++;
         $display("FAIL reset_outputs got req=%b busy=%b gnt=%b done=%b err=%b dat=%h want all zero",
                  Request, busy, cli_grant, cli_done, cli_err, sdrDataOut);
      end
      Reset = 1'b0;
      tick(); tick();
      tests_run++;
      if (busy !== 1'b0 || Request !== 1'b0) begin
         fails++; $display("FAIL reset_idle got busy=%b req=%b want 0 0", busy, Request);
      end
   endtask

   task automatic test_single();
      int n;
      cli_data = 64'h0;
      cli_data[15:0] = 16'hA5A5;
      echo_en = 1'b1;
      cli_req = 4'b0001;
      tick();
      tests_run++;
      if (Request !== 1'b1 || cli_grant !== 4'b0001 || sdrDataOut !== 16'hA5A5 || busy !== 1'b1) begin
         fails++;
         $display("FAIL single_grant got req=%b gnt=%b dat=%h busy=%b want 1 0001 a5a5 1",
                  Request, cli_grant, sdrDataOut, busy);
      end
      // Owner drops its request and changes its word mid-transfer: both must be ignored.
      cli_req = 4'b0000;
      cli_data = 64'h0;
      n = 0;
      while (cli_done == 4'b0000 && n < 40) begin tick(); n++; end
      tests_run++;
      if (n !== 6 || cli_done !== 4'b0001 || cli_grant !== 4'b0000) begin
         fails++;
         $display("FAIL single_done got cycles=%0d done=%b gnt=%b want 6 0001 0000", n, cli_done, cli_grant);
      end
      tests_run++;
      if (sdrDataOut !== 16'hA5A5) begin
         fails++; $display("FAIL single_data_hold got %h want a5a5", sdrDataOut);
      end
      tick();
      tests_run++;
      if (cli_done !== 4'b0000 || busy !== 1'b0) begin
         fails++; $display("FAIL single_after got done=%b busy=%b want 0000 0", cli_done, busy);
      end
      tick();
      tests_run++;
      if (Request !== 1'b0 || busy !== 1'b0) begin
         fails++; $display("FAIL single_no_restart got req=%b busy=%b want 0 0", Request, busy);
      end
   endtask

   task automatic test_contention();
      int n;
      int exp_order [5] = '{0, 1, 2, 3, 0};
      logic [15:0] words [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
      logic [3:0] exp_oh;
      do_reset();
      echo_en = 1'b1;
      cli_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
      cli_req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         exp_oh = 4'b0001 << exp_order[k];
         n = 0;
         while (cli_grant == 4'b0000 && n < 40) begin tick(); n++; end
         tests_run++;
         if (cli_grant !== exp_oh || sdrDataOut !== words[exp_order[k]]) begin
            fails++;
            $display("FAIL contention_grant%0d got gnt=%b dat=%h want %b %h",
                     k, cli_grant, sdrDataOut, exp_oh, words[exp_order[k]]);
         end
         n = 0;
         while (cli_done == 4'b0000 && n < 40) begin tick(); n++; end
         tests_run++;
         if (cli_done !== exp_oh) begin
            fails++; $display("FAIL contention_done%0d got %b want %b", k, cli_done, exp_oh);
         end
      end
      cli_req = 4'b0000;
      tick(); tick();
   endtask

   task automatic test_wrap();
      int n;
      // Previous contention left client 0 as last served; serve client 3 first.
      cli_req = 4'b1000;
      n = 0;
      while (cli_grant == 4'b0000 && n < 40) begin tick(); n++; end
      tests_run++;
      if (cli_grant !== 4'b1000) begin
         fails++; $display("FAIL wrap_c3 got %b want 1000", cli_grant);
      end
      n = 0;
      while (cli_done == 4'b0000 && n < 40) begin tick(); n++; end
      cli_req = 4'b1001;
      n = 0;
      while (cli_grant == 4'b0000 && n < 40) begin tick(); n++; end
      tests_run++;
      if (cli_grant !== 4'b0001) begin
         fails++; $display("FAIL wrap_c0_first got %b want 0001", cli_grant);
      end
      cli_req = 4'b1000;
      n = 0;
      while (cli_done == 4'b0000 && n < 40) begin tick(); n++; end
      n = 0;
      while (cli_grant == 4'b0000 && n < 40) begin tick(); n++; end
      tests_run++;
      if (cli_grant !== 4'b1000) begin
         fails++; $display("FAIL wrap_c3_next got %b want 1000", cli_grant);
      end
      cli_req = 4'b0000;
      n = 0;
      while (cli_done == 4'b0000 && n < 40) begin tick(); n++; end
      tick(); tick();
   endtask

   task automatic test_timeout();
      int n;
      logic saw_done;
      do_reset();
      Ack = 1'b0;
      cli_req = 4'b0011;
      tick();
      saw_done = 1'b0;
      n = 0;
      while (Request === 1'b1 && n < 40) begin
         tick(); n++;
         if (cli_done !== 4'b0000) saw_done = 1'b1;
      end
      tests_run++;
      if (n !== 10 || cli_err !== 4'b0001 || cli_grant !== 4'b0000 || saw_done !== 1'b0) begin
         fails++;
         $display("FAIL timeout_abort got cycles=%0d err=%b gnt=%b done_seen=%b want 10 0001 0000 0",
                  n, cli_err, cli_grant, saw_done);
      end
      tick();
      tests_run++;
      if (cli_err !== 4'b0000 || busy !== 1'b0) begin
         fails++; $display("FAIL timeout_err_pulse got err=%b busy=%b want 0000 0", cli_err, busy);
      end
      tick();
      tests_run++;
      if (cli_grant !== 4'b0010 || Request !== 1'b1) begin
         fails++; $display("FAIL timeout_next got gnt=%b req=%b want 0010 1", cli_grant, Request);
      end
      cli_req = 4'b0000;
      echo_en = 1'b1;
      n = 0;
      while (cli_done == 4'b0000 && n < 40) begin tick(); n++; end
      tests_run++;
      if (cli_done !== 4'b0010) begin
         fails++; $display("FAIL timeout_recover got %b want 0010", cli_done);
      end
      tick();
   endtask

   task automatic test_stuck_ack();
      int n;
      do_reset();
      cli_req = 4'b0001;
      tick();
      Ack = 1'b1;
      n = 0;
      while (Request === 1'b1 && n < 40) begin tick(); n++; end
      tests_run++;
      if (n !== 3) begin
         fails++; $display("FAIL stuck_req_fall got cycles=%0d want 3", n);
      end
      n = 0;
      while (cli_err == 4'b0000 && n < 40) begin tick(); n++; end
      tests_run++;
      if (n !== 10 || cli_err !== 4'b0001 || cli_done !== 4'b0000) begin
         fails++;
         $display("FAIL stuck_abort got cycles=%0d err=%b done=%b want 10 0001 0000", n, cli_err, cli_done);
      end
      cli_req = 4'b0000;
      repeat (5) tick();
      tests_run++;
      if (busy !== 1'b1 || cli_err !== 4'b0000 || Request !== 1'b0 || cli_grant !== 4'b0000) begin
         fails++;
         $display("FAIL stuck_hold got busy=%b err=%b req=%b gnt=%b want 1 0000 0 0000",
                  busy, cli_err, Request, cli_grant);
      end
      Ack = 1'b0;
      tick(); tick();
      tests_run++;
      if (busy !== 1'b1) begin
         fails++; $display("FAIL stuck_sync_delay got busy=%b want 1", busy);
      end
      tick();
      tests_run++;
      if (busy !== 1'b0) begin
         fails++; $display("FAIL stuck_release got busy=%b want 0", busy);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      // Client 0 was last served, so client 1 wins here.
      cli_req = 4'b0010;
      tick();
      tests_run++;
      if (cli_grant !== 4'b0010 || Request !== 1'b1) begin
         fails++; $display("FAIL rstmid_grant got gnt=%b req=%b want 0010 1", cli_grant, Request);
      end
      tick();
      #2 Reset = 1'b1;
      #1;
      tests_run++;
      if (Request !== 1'b0 || cli_grant !== 4'b0000 || busy !== 1'b0) begin
         fails++;
         $display("FAIL rstmid_async got req=%b gnt=%b busy=%b want 0 0000 0", Request, cli_grant, busy);
      end
      tick(); tick();
      tests_run++;
      if (cli_done !== 4'b0000 || cli_err !== 4'b0000) begin
         fails++; $display("FAIL rstmid_pulses got done=%b err=%b want 0000 0000", cli_done, cli_err);
      end
      Reset = 1'b0;
      cli_req = 4'b0011;
      tick();
      tests_run++;
      if (cli_grant !== 4'b0001) begin
         fails++; $display("FAIL rstmid_first got %b want 0001", cli_grant);
      end
      cli_req = 4'b0000;
      echo_en = 1'b1;
      n = 0;
      while (cli_done == 4'b0000 && n < 40) begin tick(); n++; end
      tick();
   endtask

   task automatic test_stale_ack();
      int n;
      do_reset();
      Ack = 1'b1;
      repeat (4) tick();
      tests_run++;
      if (busy !== 1'b0 || Request !== 1'b0) begin
         fails++; $display("FAIL stale_idle got busy=%b req=%b want 0 0", busy, Request);
      end
      cli_req = 4'b0001;
      tick();
      tests_run++;
      if (cli_grant !== 4'b0001 || Request !== 1'b1) begin
         fails++; $display("FAIL stale_grant got gnt=%b req=%b want 0001 1", cli_grant, Request);
      end
      tick();
      tests_run++;
      if (Request !== 1'b0) begin
         fails++; $display("FAIL stale_req_drop got %b want 0", Request);
      end
      Ack = 1'b0;
      cli_req = 4'b0000;
      n = 0;
      while (cli_done == 4'b0000 && n < 40) begin tick(); n++; end
      tests_run++;
      if (n !== 3 || cli_done !== 4'b0001) begin
         fails++; $display("FAIL stale_done got cycles=%0d done=%b want 3 0001", n, cli_done);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_wrap();
      test_timeout();
      test_stuck_ack();
      test_reset_mid();
      test_stale_ack();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
